// File: rtl/otter_mem_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package otter_mem_pkg;

    // Default number of consecutive blocked DMA cycles before DMA wins a tie.
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    // Read-return tracking: which requester owns the word arriving on mem_dout2.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DMA_RD = 2'd2
    } arb_state_e;

    // Counter width able to hold 0..limit; at least one bit.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cycles the DMA requester was refused.
module arb_starve_ctr
    import otter_mem_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned CW    = ctr_width(LIMIT)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    localparam logic [CW-1:0] LIMIT_VAL = CW'(LIMIT);

    assign sat = (cnt == LIMIT_VAL);

    // Count refused cycles, hold at the limit, drop to zero once DMA is served.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port2_arbiter.sv
// Arbitrates CPU and DMA onto a single memory port. CPU wins ties unless the
// DMA side has been refused STARVE_LIMIT cycles in a row. Reads return one
// cycle after grant; writes finish in the grant cycle.
module mem_port2_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        RST,
    // CPU side
    input  logic        cpu_rden,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    // DMA side
    input  logic        dma_rden,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_din,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_dout,
    // Memory side
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    input  logic [31:0] mem_dout2
);

    localparam int unsigned CW = ctr_width(STARVE_LIMIT);

    arb_state_e    ps;
    arb_state_e    ns;
    logic          cpu_req;
    logic          dma_req;
    logic          starve_sat;
    logic [CW-1:0] starve_cnt;

    // A write takes precedence over a simultaneous read strobe.
    assign cpu_req = cpu_rden | cpu_we;
    assign dma_req = dma_rden | dma_we;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CW    (CW)
    ) u_starve_ctr (
        .clk (clk),
        .RST (RST),
        .inc (dma_req & ~dma_gnt),
        .clr (dma_gnt),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    // Grant selection and memory port steering; all quiet while in reset.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        mem_addr2 = '0;
        mem_din2  = '0;
        if (!RST) begin
            if (dma_req && (!cpu_req || starve_sat)) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        if (cpu_gnt) begin
            mem_we2   = cpu_we;
            mem_rden2 = cpu_rden & ~cpu_we;
            mem_addr2 = cpu_addr;
            mem_din2  = cpu_din;
        end else if (dma_gnt) begin
            mem_we2   = dma_we;
            mem_rden2 = dma_rden & ~dma_we;
            mem_addr2 = dma_addr;
            mem_din2  = dma_din;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt & ~RST;

    // Return-owner state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            ps <= ST_IDLE;
        end else begin
            ps <= ns;
        end
    end

    // Next owner of the returning read word, and read-data routing.
    always_comb begin
        ns         = ST_IDLE;
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        cpu_dout   = '0;
        dma_dout   = '0;
        if (cpu_gnt && cpu_rden && !cpu_we) begin
            ns = ST_CPU_RD;
        end else if (dma_gnt && dma_rden && !dma_we) begin
            ns = ST_DMA_RD;
        end
        // Gating by RST suppresses a return for a read granted just before reset.
        if (!RST) begin
            unique case (ps)
                ST_CPU_RD: begin
                    cpu_rvalid = 1'b1;
                    cpu_dout   = mem_dout2;
                end
                ST_DMA_RD: begin
                    dma_rvalid = 1'b1;
                    dma_dout   = mem_dout2;
                end
                default: ;
            endcase
        end
    end

endmodule
